// File: rtl/decryption_controller.sv
// -----------------------------------------------------------------------------
// decryption_controller
//
// Front-end sequencer for the decryption subsystem. Collects one serial
// ciphertext message and forwards it to the engine chosen by sel_i. The message
// is closed by injecting the start token. Upstream is held off (busy_o) until
// that engine has finished emitting plaintext. The selected engine's output
// stream is returned through one registered output port.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_i        : ciphertext character or start token
//   valid_i       : data_i qualifier
//   sel_i         : engine select (0 Caesar, 1 Scytale, 2 ZigZag, 3 reserved)
//   busy_o        : high while input is not accepted (WAIT / DRAIN)
//   eng_data_o    : shared data bus towards the engines
//   eng_valid_o   : one-hot valid towards the engines
//   eng_busy_i    : busy flags from engines 0..2
//   eng_data_i    : engine output data, engine n at [n*D_WIDTH +: D_WIDTH]
//   eng_valid_i   : engine output valids
//   data_o        : plaintext character (zero when valid_o is low)
//   valid_o       : data_o qualifier
//   err_o         : one-cycle error pulse
// -----------------------------------------------------------------------------
module decryption_controller #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 WAIT_TIMEOUT           = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [D_WIDTH-1:0]     data_i,
  input  logic                   valid_i,
  input  logic [1:0]             sel_i,
  output logic                   busy_o,
  output logic [D_WIDTH-1:0]     eng_data_o,
  output logic [2:0]             eng_valid_o,
  input  logic [2:0]             eng_busy_i,
  input  logic [3*D_WIDTH-1:0]   eng_data_i,
  input  logic [2:0]             eng_valid_i,
  output logic [D_WIDTH-1:0]     data_o,
  output logic                   valid_o,
  output logic                   err_o
);

  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_NOF_CHARS);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          sel_r, sel_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
  logic [D_WIDTH-1:0]  eng_data_r;
  logic [2:0]          eng_valid_r;
  logic [D_WIDTH-1:0]  data_r;
  logic                valid_r;
  logic                err_r, err_s;
  logic                fwd_s;
  logic                busy_s;
  logic                accept_s;
  logic                is_token_s;
  logic                eng_busy_sel_s;
  logic                eng_valid_sel_s;
  logic [D_WIDTH-1:0]  eng_data_sel_s;

  // One-hot engine valid for a given select; the reserved code maps to none.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      2'd0:    sel_onehot = 3'b001;
      2'd1:    sel_onehot = 3'b010;
      2'd2:    sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  endfunction

  assign busy_s      = (state_r == ST_WAIT) || (state_r == ST_DRAIN);
  assign accept_s    = valid_i && !busy_s;
  assign is_token_s  = (data_i == START_DECRYPTION_TOKEN);

  assign busy_o      = busy_s;
  assign eng_data_o  = eng_data_r;
  assign eng_valid_o = eng_valid_r;
  assign data_o      = data_r;
  assign valid_o     = valid_r;
  assign err_o       = err_r;

  // Pick busy/valid/data of the latched engine; other engines are ignored.
  always_comb begin
    eng_busy_sel_s  = 1'b0;
    eng_valid_sel_s = 1'b0;
    eng_data_sel_s  = {D_WIDTH{1'b0}};
    case (sel_r)
      2'd0: begin
        eng_busy_sel_s  = eng_busy_i[0];
        eng_valid_sel_s = eng_valid_i[0];
        eng_data_sel_s  = eng_data_i[0*D_WIDTH +: D_WIDTH];
      end
      2'd1: begin
        eng_busy_sel_s  = eng_busy_i[1];
        eng_valid_sel_s = eng_valid_i[1];
        eng_data_sel_s  = eng_data_i[1*D_WIDTH +: D_WIDTH];
      end
      2'd2: begin
        eng_busy_sel_s  = eng_busy_i[2];
        eng_valid_sel_s = eng_valid_i[2];
        eng_data_sel_s  = eng_data_i[2*D_WIDTH +: D_WIDTH];
      end
      default: begin
        eng_busy_sel_s  = 1'b0;
        eng_valid_sel_s = 1'b0;
        eng_data_sel_s  = {D_WIDTH{1'b0}};
      end
    endcase
  end

  // Next-state, counters, forwarding and error decisions.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    cnt_s      = cnt_r;
    wait_cnt_s = wait_cnt_r;
    fwd_s      = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_token_s) begin
            // Empty message: the token is silently dropped.
            state_s = ST_IDLE;
          end else if (sel_i == 2'd3) begin
            err_s = 1'b1;
          end else begin
            sel_s   = sel_i;
            cnt_s   = CNT_ONE;
            fwd_s   = 1'b1;
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (is_token_s) begin
            fwd_s      = 1'b1;
            wait_cnt_s = WAIT_ZERO;
            state_s    = ST_WAIT;
          end else if (cnt_r < CNT_MAX) begin
            fwd_s = 1'b1;
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            // Overlong message: drop the character, keep waiting for the token.
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (eng_busy_sel_s) begin
          state_s = ST_DRAIN;
        end else if (wait_cnt_r >= WAIT_LAST) begin
          err_s   = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_IDLE;
        end else if (wait_cnt_r != WAIT_SAT) begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end
      ST_DRAIN: begin
        if (!eng_busy_sel_s) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: latched select, counters, engine bus and output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= 2'd0;
      cnt_r       <= CNT_ZERO;
      wait_cnt_r  <= WAIT_ZERO;
      eng_data_r  <= {D_WIDTH{1'b0}};
      eng_valid_r <= 3'b000;
      data_r      <= {D_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      sel_r       <= sel_s;
      cnt_r       <= cnt_s;
      wait_cnt_r  <= wait_cnt_s;
      eng_valid_r <= fwd_s ? sel_onehot(sel_s) : 3'b000;
      // The engine bus keeps its last value when nothing is forwarded.
      eng_data_r  <= fwd_s ? data_i : eng_data_r;
      valid_r     <= eng_valid_sel_s;
      data_r      <= eng_valid_sel_s ? eng_data_sel_s : {D_WIDTH{1'b0}};
      err_r       <= err_s;
    end
  end

endmodule

// File: tb/tb_decryption_controller.sv
module tb_decryption_controller;

  localparam logic [7:0] TOK = 8'hFA;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic        busy_o;
  logic [7:0]  eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        err_o;

  decryption_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .sel_i       (sel_i),
    .busy_o      (busy_o),
    .eng_data_o  (eng_data_o),
    .eng_valid_o (eng_valid_o),
    .eng_busy_i  (eng_busy_i),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: expected forwards {lane one-hot, byte}, expected
  // plaintext bytes from the selected engine, and pending error pulses.
  logic [10:0] exp_fwd_q[$];
  logic [7:0]  exp_out_q[$];
  int          exp_err = 0;
  logic [7:0]  msg_q[$];

  bit eng_respond = 1'b1;
  bit distract    = 1'b0;
  bit eng_active  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h, nothing expected", name, got);
  endtask

  // Monitor / scoreboard: compares every DUT output event against the queues.
  initial begin
    logic [10:0] ef;
    logic        err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (eng_valid_o != 3'b000) begin
          if (exp_fwd_q.size() == 0) fail_now("fwd_unexpected", 32'({eng_valid_o, eng_data_o}));
          else begin
            ef = exp_fwd_q.pop_front();
            check("fwd", 32'({eng_valid_o, eng_data_o}), 32'(ef));
          end
        end
        if (valid_o) begin
          if (exp_out_q.size() == 0) fail_now("out_unexpected", 32'(data_o));
          else check("out_data", 32'(data_o), 32'(exp_out_q.pop_front()));
        end else begin
          check("out_idle_zero", 32'(data_o), 32'd0);
        end
        if (err_o) begin
          if (exp_err == 0) fail_now("err_unexpected", 32'd1);
          else exp_err--;
          if (err_prev) fail_now("err_double", 32'd1);
        end
        err_prev = err_o;
      end else begin
        err_prev = 1'b0;
      end
    end
  end

  // Engine model: on a token raise busy, emit a few bytes, then drop busy.
  initial begin
    int lane;
    int dly;
    int nb;
    logic [7:0] b;
    eng_busy_i  = 3'b000;
    eng_valid_i = 3'b000;
    eng_data_i  = 24'h000000;
    forever begin
      @(negedge clk);
      if (rst_n && eng_respond && eng_valid_o != 3'b000 && eng_data_o == TOK) begin
        lane = (eng_valid_o == 3'b001) ? 0 : ((eng_valid_o == 3'b010) ? 1 : 2);
        eng_active = 1'b1;
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) @(negedge clk);
        eng_busy_i[lane] = 1'b1;
        nb = $urandom_range(2, 6);
        for (int k = 0; k < nb; k++) begin
          @(negedge clk);
          if (!rst_n) break;
          b = 8'($urandom_range(1, 255));
          eng_valid_i = 3'b000;
          eng_data_i  = 24'h000000;
          // With a distractor, odd beats carry only engine 0 traffic.
          if (!(distract && (k % 2 == 1))) begin
            eng_valid_i[lane]          = 1'b1;
            eng_data_i[lane*8 +: 8]    = b;
            exp_out_q.push_back(b);
          end
          if (distract) begin
            eng_valid_i[0]   = 1'b1;
            eng_data_i[7:0]  = 8'h41;
          end
        end
        @(negedge clk);
        eng_valid_i = 3'b000;
        eng_data_i  = 24'h000000;
        eng_busy_i  = 3'b000;
        eng_active  = 1'b0;
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic [1:0] s);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = d;
    sel_i   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_msg(input int n);
    logic [7:0] ch;
    msg_q.delete();
    for (int i = 0; i < n; i++) begin
      ch = 8'($urandom_range(0, 255));
      while (ch == TOK) ch = 8'($urandom_range(0, 255));
      msg_q.push_back(ch);
    end
  endtask

  // Sends msg_q then the token; model: first 50 chars forwarded, rest error.
  task automatic send_msg(input logic [1:0] s);
    logic [2:0] oh;
    oh = 3'b001 << s;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (i < 50) exp_fwd_q.push_back({oh, msg_q[i]});
      else exp_err++;
      drive(msg_q[i], (i == 0) ? s : 2'($urandom_range(0, 3)));
      if (i >= 50) begin
        check("overflow_err", 32'(err_o), 32'd1);
        check("overflow_drop", 32'(eng_valid_o), 32'd0);
      end else begin
        check("fwd_lane", 32'(eng_valid_o), 32'(oh));
      end
    end
    exp_fwd_q.push_back({oh, TOK});
    drive(TOK, 2'($urandom_range(0, 3)));
    check("busy_rise", 32'(busy_o), 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] s);
    logic prev;
    int   k;
    prev = 1'b0;
    k    = 0;
    while (busy_o && k < 200) begin
      prev = eng_busy_i[s];
      @(posedge clk);
      #1;
      k++;
    end
    if (busy_o) fail_now("busy_stuck", 32'd1);
    else begin
      check("busy_fall_timing", 32'(prev), 32'd1);
      check("busy_fall_engine_idle", 32'(eng_busy_i[s]), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int k;
    logic [1:0] s;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    sel_i   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_eng_valid", 32'(eng_valid_o), 32'd0);
    check("rst_eng_data", 32'(eng_data_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scytale "HLELO", plus a character offered while busy (must be dropped).
    msg_q.delete();
    msg_q.push_back(8'h48); msg_q.push_back(8'h4C); msg_q.push_back(8'h45);
    msg_q.push_back(8'h4C); msg_q.push_back(8'h4F);
    send_msg(2'd1);
    drive(8'h5A, 2'd1);
    valid_i = 1'b0;
    wait_done(2'd1);

    // Reserved select.
    exp_err++;
    drive(8'h41, 2'd3);
    valid_i = 1'b0;
    check("sel3_err", 32'(err_o), 32'd1);
    check("sel3_no_fwd", 32'(eng_valid_o), 32'd0);
    check("sel3_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    check("sel3_err_single", 32'(err_o), 32'd0);
    check("sel3_idle", 32'(busy_o), 32'd0);

    // Overlong Caesar message: 51 chars.
    rand_msg(51);
    send_msg(2'd0);
    wait_done(2'd0);

    // ZigZag with an engine that never goes busy.
    eng_respond = 1'b0;
    exp_err++;
    msg_q.delete();
    msg_q.push_back(8'h58);
    send_msg(2'd2);
    bc = 1;
    k  = 0;
    while (k < 50) begin
      @(posedge clk);
      #1;
      k++;
      if (busy_o) bc++;
      else break;
    end
    check("timeout_wait_cycles", 32'(bc), 32'd4);
    check("timeout_err", 32'(err_o), 32'd1);
    check("timeout_idle", 32'(busy_o), 32'd0);
    eng_respond = 1'b1;

    // Scytale drain with engine 0 chattering on its own valid.
    distract = 1'b1;
    rand_msg(3);
    send_msg(2'd1);
    wait_done(2'd1);
    distract = 1'b0;

    // Asynchronous reset in the middle of a Scytale drain.
    rand_msg(4);
    send_msg(2'd1);
    k = 0;
    while (!valid_o && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("pre_reset_valid", 32'(valid_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_eng_valid", 32'(eng_valid_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    repeat (2) @(negedge clk);
    k = 0;
    while (eng_active && k < 20) begin
      @(negedge clk);
      k++;
    end
    exp_out_q.delete();
    exp_fwd_q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // After reset a Caesar message must reach engine 0 only.
    rand_msg(3);
    send_msg(2'd0);
    wait_done(2'd0);

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      s = 2'($urandom_range(0, 2));
      rand_msg($urandom_range(1, 8));
      send_msg(s);
      wait_done(s);
    end

    repeat (5) @(negedge clk);
    check("fwd_q_empty", 32'(exp_fwd_q.size()), 32'd0);
    check("out_q_empty", 32'(exp_out_q.size()), 32'd0);
    check("err_all_seen", 32'(exp_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
